// File: rtl/ram_responder.sv
// Word-addressed backing memory that answers cache requests after a fixed latency.
// Any change on data/addr/wr versus the last accepted request counts as a new request.
module ram_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data,
  input  logic [31:0] addr,
  input  logic        wr,
  output logic        response,
  output logic [31:0] out,
  output logic        busy
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                 state_q;
  logic [31:0]            reqData_q;
  logic [31:0]            reqAddr_q;
  logic                   reqWr_q;
  logic [7:0]             cnt_q;
  logic                   done_q;
  logic [31:0]            out_q;
  logic [31:0]            mem [DEPTH];

  logic                   mismatch;
  logic                   complete;
  logic [ADDR_BITS-1:0]   reqIndex;

  assign mismatch = (data != reqData_q) | (addr != reqAddr_q) | (wr != reqWr_q);
  assign complete = (state_q == BUSY) && !mismatch && (cnt_q == 8'd0);
  assign reqIndex = reqAddr_q[ADDR_BITS-1:0];

  // Response drops combinationally so the initiator never sees a stale completion.
  assign response = done_q & ~mismatch;
  assign busy     = (state_q == BUSY);
  assign out      = out_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      reqData_q <= 32'd0;
      reqAddr_q <= 32'd0;
      reqWr_q   <= 1'b0;
      cnt_q     <= 8'd0;
      done_q    <= 1'b1;
      out_q     <= 32'd0;
    end else if (mismatch) begin
      // A changed request always restarts the full latency, abandoning any pending one.
      state_q   <= BUSY;
      reqData_q <= data;
      reqAddr_q <= addr;
      reqWr_q   <= wr;
      cnt_q     <= 8'(LATENCY - 1);
      done_q    <= 1'b0;
    end else if (complete) begin
      out_q   <= reqWr_q ? reqData_q : mem[reqIndex];
      done_q  <= 1'b1;
      state_q <= IDLE;
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  // Memory has no reset; a write lands only when its request completes.
  always_ff @(posedge clk) begin
    if (rst_n && complete && reqWr_q) begin
      mem[reqIndex] <= reqData_q;
    end
  end

endmodule
